// File: rtl/bike_pkg.sv
// Shared types and constants for the bike computer arithmetic blocks.
package bike_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

  localparam logic CLIENT_CUR = 1'b0;
  localparam logic CLIENT_AVG = 1'b1;

  // Round-robin pick between two requesters: on a tie the client that was
  // not served last wins, otherwise whichever one is asking.
  function automatic logic rrPick(input logic want0, input logic want1,
                                  input logic lastServed);
    logic pick;
    pick = CLIENT_CUR;
    if (want0 && want1) begin
      pick = ~lastServed;
    end else if (want1) begin
      pick = CLIENT_AVG;
    end
    return pick;
  endfunction

endpackage

// File: rtl/div_core.sv
// Single-client radix-2 restoring divider datapath: shifts the dividend out
// MSB-first, builds the quotient in the same register, one bit per step.
module div_core
  import bike_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             last_o,
  output logic             divZero_o,
  output logic [WIDTH-1:0] quotNext_o,
  output logic [WIDTH-1:0] remNext_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;
  logic             divZero_q;

  logic [WIDTH:0]   trial;
  logic             geq;
  logic [WIDTH-1:0] dvd_d;
  logic [WIDTH-1:0] rem_d;

  // One restoring step. The shifted partial remainder is WIDTH+1 bits wide so
  // the compare against the divisor can never overflow; after a subtract the
  // result is always below the divisor, so the low WIDTH bits hold it exactly.
  always_comb begin
    trial = {rem_q, dvd_q[WIDTH-1]};
    geq   = (trial >= {1'b0, dsr_q});
    rem_d = trial[WIDTH-1:0];
    if (geq) begin
      rem_d = trial[WIDTH-1:0] - dsr_q;
    end
    dvd_d = {dvd_q[WIDTH-2:0], geq};
  end

  // Load operands on start, then advance one quotient bit per enabled step.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      divZero_q <= 1'b0;
    end else if (start_i) begin
      dvd_q     <= dividend_i;
      dsr_q     <= divisor_i;
      rem_q     <= '0;
      cnt_q     <= CNT_LOAD;
      divZero_q <= (divisor_i == '0);
    end else if (step_i && (cnt_q != '0)) begin
      dvd_q <= dvd_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q - CNT_ONE;
    end
  end

  assign last_o     = (cnt_q == CNT_ONE);
  assign divZero_o  = divZero_q;
  assign quotNext_o = dvd_d;
  assign remNext_o  = rem_d;

endmodule

// File: rtl/shared_divider.sv
// Two-client shared divider: pending-request capture, round-robin grant,
// and the busy/ready/select handshake around a single div_core.
module shared_divider
  import bike_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] dividend0,
  input  logic [WIDTH-1:0] divisor0,
  input  logic             req1,
  input  logic [WIDTH-1:0] dividend1,
  input  logic [WIDTH-1:0] divisor1,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             select
);

  div_state_t       state_q;
  logic             pend0_q;
  logic             pend1_q;
  logic             lastServed_q;
  logic             busy_q;
  logic             ready_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             sel_q;

  logic             pend0_d;
  logic             pend1_d;
  logic             want0;
  logic             want1;
  logic             grantValid;
  logic             grantSel;
  logic [WIDTH-1:0] grantDividend;
  logic [WIDTH-1:0] grantDivisor;
  logic             coreStep;

  logic             coreLast;
  logic             coreDivZero;
  logic [WIDTH-1:0] coreQuot;
  logic [WIDTH-1:0] coreRem;

  // Merge live requests with pending bits, pick a winner while idle, and
  // clear only the granted client's pending bit so no request is lost.
  always_comb begin
    want0         = pend0_q | req0;
    want1         = pend1_q | req1;
    grantValid    = (state_q == IDLE) && (want0 || want1);
    grantSel      = rrPick(want0, want1, lastServed_q);
    pend0_d       = want0 & ~(grantValid & (grantSel == CLIENT_CUR));
    pend1_d       = want1 & ~(grantValid & (grantSel == CLIENT_AVG));
    grantDividend = (grantSel == CLIENT_AVG) ? dividend1 : dividend0;
    grantDivisor  = (grantSel == CLIENT_AVG) ? divisor1 : divisor0;
    coreStep      = (state_q == RUN);
  end

  div_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .start_i   (grantValid),
    .step_i    (coreStep),
    .dividend_i(grantDividend),
    .divisor_i (grantDivisor),
    .last_o    (coreLast),
    .divZero_o (coreDivZero),
    .quotNext_o(coreQuot),
    .remNext_o (coreRem)
  );

  // Control FSM with registered handshake outputs; a divide by zero runs the
  // full length and forces an all-ones quotient (remainder is the dividend).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pend0_q      <= 1'b0;
      pend1_q      <= 1'b0;
      lastServed_q <= CLIENT_AVG;
      busy_q       <= 1'b0;
      ready_q      <= 1'b0;
      quot_q       <= '0;
      rem_q        <= '0;
      sel_q        <= CLIENT_CUR;
    end else begin
      pend0_q <= pend0_d;
      pend1_q <= pend1_d;
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grantValid) begin
            sel_q        <= grantSel;
            lastServed_q <= grantSel;
            busy_q       <= 1'b1;
            state_q      <= RUN;
          end
        end
        RUN: begin
          if (coreLast) begin
            quot_q  <= coreDivZero ? '1 : coreQuot;
            rem_q   <= coreRem;
            ready_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign ready     = ready_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign select    = sel_q;

endmodule

// File: tb/tb_shared_divider.sv
// Scoreboard bench for shared_divider: stimulus pushes expected results,
// a monitor pops and compares on every ready pulse.
module tb_shared_divider;

  logic        clk;
  logic        rst;
  logic        req0;
  logic [15:0] dividend0;
  logic [15:0] divisor0;
  logic        req1;
  logic [15:0] dividend1;
  logic [15:0] divisor1;
  logic        busy;
  logic        ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        select;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        sel;
    int          cycle;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   busyFallDue = 0;

  shared_divider #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .dividend0(dividend0),
    .divisor0 (divisor0),
    .req1     (req1),
    .dividend1(dividend1),
    .divisor1 (divisor1),
    .busy     (busy),
    .ready    (ready),
    .quotient (quotient),
    .remainder(remainder),
    .select   (select)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index used for latency checks.
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic setReq(input logic c, input logic [15:0] dd, input logic [15:0] ds);
    if (c) begin
      req1 = 1'b1; dividend1 = dd; divisor1 = ds;
    end else begin
      req0 = 1'b1; dividend0 = dd; divisor0 = ds;
    end
  endtask

  task automatic expectResult(input logic [15:0] q, input logic [15:0] r,
                              input logic sel, input int readyCycle);
    exp_t e;
    e.q = q; e.r = r; e.sel = sel; e.cycle = readyCycle;
    sb.push_back(e);
  endtask

  // One-cycle request from an idle divider; the result is due 17 cycles later.
  task automatic applyStimulus(input logic c, input logic [15:0] dd, input logic [15:0] ds,
                               input logic [15:0] q, input logic [15:0] r);
    @(posedge clk); #1;
    setReq(c, dd, ds);
    expectResult(q, r, c, cyc + 17);
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic waitIdle();
    bit done;
    done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && !ready && sb.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL waitIdle: timed out with %0d results outstanding", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: compare every ready pulse against the oldest expectation, and
  // check that busy drops in the cycle after each result.
  always @(negedge clk) begin
    if (busyFallDue) begin
      busyFallDue = 0;
      if (!rst) checkOutput("busyFall", busy, 0);
    end
    if (!rst && ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedReady: got quotient %0d select %0d with nothing expected",
                 quotient, select);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("quotient", quotient, e.q);
        checkOutput("remainder", remainder, e.r);
        checkOutput("select", select, e.sel);
        checkOutput("readyCycle", cyc, e.cycle);
        checkOutput("busyAtReady", busy, 1);
        busyFallDue = 1;
      end
    end
  end

  // Overall time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int readyCount;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    dividend0 = '0; divisor0 = '0; dividend1 = '0; divisor1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetReady", ready, 0);
    checkOutput("resetQuotient", quotient, 0);
    checkOutput("resetRemainder", remainder, 0);
    checkOutput("resetSelect", select, 0);

    applyStimulus(1'b1, 16'd18000, 16'd600, 16'd30, 16'd0);
    checkOutput("busyRise", busy, 1);
    waitIdle();

    applyStimulus(1'b0, 16'd65535, 16'd1, 16'd65535, 16'd0);
    waitIdle();
    applyStimulus(1'b0, 16'd7, 16'd9, 16'd0, 16'd7);
    waitIdle();
    applyStimulus(1'b1, 16'd1234, 16'd0, 16'hFFFF, 16'd1234);
    waitIdle();

    // Simultaneous requests straight after reset: client 0 first.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    setReq(1'b0, 16'd100, 16'd7);
    setReq(1'b1, 16'd1000, 16'd33);
    expectResult(16'd14, 16'd2, 1'b0, cyc + 17);
    expectResult(16'd30, 16'd10, 1'b1, cyc + 35);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    waitIdle();

    // Three client-1 pulses during client 0's run collapse into one operation.
    applyStimulus(1'b0, 16'd5000, 16'd50, 16'd100, 16'd0);
    expectResult(16'd99, 16'd9, 1'b1, cyc + 34);
    repeat (3) begin
      @(posedge clk); #1;
      setReq(1'b1, 16'd999, 16'd10);
      @(posedge clk); #1;
      req1 = 1'b0;
    end
    waitIdle();
    repeat (3) @(posedge clk);
    #1 checkOutput("noExtraOp", busy, 0);

    // Reset in the eighth RUN cycle aborts the operation without a result.
    @(posedge clk); #1;
    setReq(1'b0, 16'd40000, 16'd3);
    @(posedge clk); #1;
    req0 = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortQuotient", quotient, 0);
    readyCount = 0;
    repeat (20) begin
      @(negedge clk);
      if (ready) readyCount++;
    end
    checkOutput("abortNoReady", readyCount, 0);

    applyStimulus(1'b1, 16'd40000, 16'd3, 16'd13333, 16'd1);
    waitIdle();

    checkOutput("scoreboardEmpty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
